mmio_timer: RTL and testbench

// - Memory-mapped Count/Compare timer on the CPU data bus, alongside RAM; same we/addr/wdata/rdata bus.
// - Feeds the CP0 timer_int input: raises a level interrupt when COUNT matches COMPARE.
// - The top level steers CPU ram-bus reads to this block when sel=1, else to RAM.

---
 rtl/mips_mmio_pkg.sv | 16 +
 rtl/timer_prescaler.sv | 31 +++
 rtl/mmio_timer.sv | 124 ++++++++++++
 tb/tb_mmio_timer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mmio_pkg.sv
// Shared constants for the memory-mapped Count/Compare timer: register offsets,
// CTRL bit positions and the COMPARE reset value.
package mips_mmio_pkg;

  localparam logic [1:0] TMR_CTRL    = 2'd0;
  localparam logic [1:0] TMR_COUNT   = 2'd1;
  localparam logic [1:0] TMR_COMPARE = 2'd2;
  localparam logic [1:0] TMR_STATUS  = 2'd3;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int CTRL_AR = 2;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by DIV while enabled; tick is high in the cycle the divider sits at DIV-1.
// The divider is held at 0 while disabled, so the first tick lands DIV cycles after enable.
module timer_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped Count/Compare timer with a level interrupt to CP0.
// Optional auto-reload on match is built when TIMER_AUTORELOAD_EN is defined.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        timer_int
);

  import mips_mmio_pkg::*;

  logic        en_q;
  logic        ie_q;
  logic        ar_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        pending_q;

  logic wr;
  logic ctrl_wr;
  logic count_wr;
  logic compare_wr;
  logic status_wr;
  logic tick_raw;
  logic tick;
  logic equal;
  logic match;
  logic unused_addr_bits;

  assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr         = we & sel;
  assign ctrl_wr    = wr & (addr[3:2] == TMR_CTRL);
  assign count_wr   = wr & (addr[3:2] == TMR_COUNT);
  assign compare_wr = wr & (addr[3:2] == TMR_COMPARE);
  assign status_wr  = wr & (addr[3:2] == TMR_STATUS);
  assign unused_addr_bits = ^addr[1:0];

  timer_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_q),
    .tick  (tick_raw)
  );

  // A tick coinciding with software turning EN off is dropped so COUNT holds.
  assign tick  = tick_raw & ~(ctrl_wr & ~wdata[CTRL_EN]);
  assign equal = (count_q == compare_q);
  assign match = tick & ~count_wr & equal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      ie_q <= 1'b0;
    end else if (ctrl_wr) begin
      en_q <= wdata[CTRL_EN];
      ie_q <= wdata[CTRL_IE];
    end
  end

`ifdef TIMER_AUTORELOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q <= 1'b0;
    end else if (ctrl_wr) begin
      ar_q <= wdata[CTRL_AR];
    end
  end
`else
  assign ar_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (count_wr) begin
      count_q <= wdata;
    end else if (tick) begin
      count_q <= (ar_q && equal) ? 32'd0 : count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare_q <= COMPARE_RST;
    end else if (compare_wr) begin
      compare_q <= wdata;
    end
  end

  // Set beats both clear sources (W1C and COMPARE rewrite).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (match) begin
      pending_q <= 1'b1;
    end else if (compare_wr || (status_wr && wdata[0])) begin
      pending_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        TMR_CTRL:    rdata = {29'd0, ar_q, ie_q, en_q};
        TMR_COUNT:   rdata = count_q;
        TMR_COMPARE: rdata = compare_q;
        default:     rdata = {31'd0, pending_q};
      endcase
    end
  end

  assign timer_int = pending_q & ie_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed bus traffic against a DIV=4 and a DIV=1 instance;
// expected {sel, timer_int, rdata} triples are queued and checked on the falling edge.
module tb_mmio_timer;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_CNT  = BASE + 32'h4;
  localparam logic [31:0] A_CMP  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata0, rdata1;
  logic        sel0, sel1, int0, int1;

  always #5 clk = ~clk;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .sel(sel0), .timer_int(int0)
  );

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_DIV(1)) u_dut_div1 (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .sel(sel1), .timer_int(int1)
  );

  // scoreboard
  logic [33:0] exp_q[$];
  string       name_q[$];
  logic        dut_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        mon_req = 1'b0;
  logic [33:0] mon_exp;
  logic [33:0] mon_act;
  logic        mon_dut;
  string       mon_name;

  always @(negedge clk) begin
    if (mon_req) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: output presented, expected queue empty");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        mon_dut  = dut_q.pop_front();
        mon_act  = mon_dut ? {sel1, int1, rdata1} : {sel0, int0, rdata0};
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL %s: got sel=%0b int=%0b rdata=%h, want sel=%0b int=%0b rdata=%h",
                   mon_name, mon_act[33], mon_act[32], mon_act[31:0],
                   mon_exp[33], mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  // driver tasks: each is entered and left 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step(1);
    we    = 1'b0;
  endtask

  task automatic rd(input logic d, input logic [31:0] a, input logic es,
                    input logic ei, input logic [31:0] e, input string nm);
    addr = a;
    we   = 1'b0;
    exp_q.push_back({es, ei, e});
    name_q.push_back(nm);
    dut_q.push_back(d);
    mon_req = 1'b1;
    step(1);
    mon_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    rd(1'b0, A_CTRL, 1'b1, 1'b0, 32'h0,         {tag, "_ctrl"});
    rd(1'b0, A_CNT,  1'b1, 1'b0, 32'h0,         {tag, "_count"});
    rd(1'b0, A_CMP,  1'b1, 1'b0, 32'hFFFF_FFFF, {tag, "_compare"});
    rd(1'b0, A_STAT, 1'b1, 1'b0, 32'h0,         {tag, "_status"});
  endtask

  initial begin
    step(2);
    rst_n = 1'b1;
    step(1);

    // reset state, decode and window
    check_reset_values("por");
    rd(1'b1, A_CTRL, 1'b1, 1'b0, 32'h0, "por_ctrl_div1");
    rd(1'b0, 32'h2000_0004, 1'b0, 1'b0, 32'h0, "unselected_read");
    wr(32'h2000_0004, 32'd55);
    rd(1'b0, BASE + 32'h6, 1'b1, 1'b0, 32'h0, "unselected_write_ignored");

    // prescale: first tick 4 cycles after EN write, then every 4
    wr(A_CTRL, 32'h1);
    rd(1'b0, A_CNT, 1'b1, 1'b0, 32'd0, "pre_c1");
    rd(1'b0, A_CNT, 1'b1, 1'b0, 32'd0, "pre_c2");
    rd(1'b0, A_CNT, 1'b1, 1'b0, 32'd0, "pre_c3");
    rd(1'b0, A_CNT, 1'b1, 1'b0, 32'd0, "pre_c4_before_tick");
    rd(1'b0, A_CNT, 1'b1, 1'b0, 32'd1, "pre_first_tick");
    step(14);
    rd(1'b0, A_CNT, 1'b1, 1'b0, 32'd4, "pre_c20");
    rd(1'b0, A_CNT, 1'b1, 1'b0, 32'd5, "pre_c21");
    wr(A_CTRL, 32'h0);
    step(10);
    rd(1'b0, A_CNT, 1'b1, 1'b0, 32'd5, "en0_freeze");

    // match and interrupt, then W1C
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h3);
    step(15);
    rd(1'b0, A_STAT, 1'b1, 1'b0, 32'd0, "match_not_yet");
    rd(1'b0, A_STAT, 1'b1, 1'b1, 32'd1, "match_pending");
    rd(1'b0, A_CNT,  1'b1, 1'b1, 32'd4, "match_count4");
    wr(A_STAT, 32'h1);
    rd(1'b0, A_STAT, 1'b1, 1'b0, 32'd0, "w1c_clears");

    // collisions
    do_reset();
    wr(A_CMP, 32'd0);
    wr(A_CTRL, 32'h3);
    step(3);
    wr(A_STAT, 32'h1);
    rd(1'b0, A_STAT, 1'b1, 1'b1, 32'd1, "w1c_vs_match_set_wins");
    wr(A_CTRL, 32'h1);
    rd(1'b0, A_STAT, 1'b1, 1'b0, 32'd1, "ie0_masks_keeps_pending");
    wr(A_CMP, 32'd50);
    rd(1'b0, A_STAT, 1'b1, 1'b0, 32'd0, "compare_write_clears");
    wr(A_CTRL, 32'h3);
    step(1);
    wr(A_CNT, 32'd100);
    rd(1'b0, A_CNT, 1'b1, 1'b0, 32'd100, "count_write_vs_tick");
    wr(A_CMP, 32'd100);
    step(1);
    wr(A_CNT, 32'd7);
    rd(1'b0, A_STAT, 1'b1, 1'b0, 32'd0, "count_write_no_match");
    rd(1'b0, A_CNT,  1'b1, 1'b0, 32'd7, "count_write_value");
    step(1);
    wr(A_CTRL, 32'h2);
    rd(1'b0, A_CNT, 1'b1, 1'b0, 32'd7, "en_off_drops_tick");

    // wrap: FFFF_FFFF -> 0 without match, then match on 0
    do_reset();
    wr(A_CNT, 32'hFFFF_FFFF);
    wr(A_CMP, 32'd0);
    wr(A_CTRL, 32'h3);
    step(4);
    rd(1'b0, A_CNT,  1'b1, 1'b0, 32'd0, "wrap_count0");
    rd(1'b0, A_STAT, 1'b1, 1'b0, 32'd0, "wrap_no_pending");
    step(2);
    rd(1'b0, A_STAT, 1'b1, 1'b1, 32'd1, "wrap_next_pending");
    rd(1'b0, A_CNT,  1'b1, 1'b1, 32'd1, "wrap_count1");

    // auto-reload on the DIV=1 instance
    do_reset();
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h7);
`ifdef TIMER_AUTORELOAD_EN
    rd(1'b1, A_CTRL, 1'b1, 1'b0, 32'd7, "ar_ctrl");
    rd(1'b1, A_CNT,  1'b1, 1'b0, 32'd1, "ar_c1");
    rd(1'b1, A_CNT,  1'b1, 1'b0, 32'd2, "ar_c2");
    rd(1'b1, A_CNT,  1'b1, 1'b1, 32'd0, "ar_reload");
    wr(A_STAT, 32'h1);
    rd(1'b1, A_STAT, 1'b1, 1'b0, 32'd0, "ar_cleared");
    rd(1'b1, A_STAT, 1'b1, 1'b1, 32'd1, "ar_period3");
`else
    rd(1'b1, A_CTRL, 1'b1, 1'b0, 32'd3, "noar_ctrl");
    rd(1'b1, A_CNT,  1'b1, 1'b0, 32'd1, "noar_c1");
    rd(1'b1, A_CNT,  1'b1, 1'b0, 32'd2, "noar_c2");
    rd(1'b1, A_CNT,  1'b1, 1'b1, 32'd3, "noar_c3");
    wr(A_STAT, 32'h1);
    rd(1'b1, A_STAT, 1'b1, 1'b0, 32'd0, "noar_cleared");
    rd(1'b1, A_STAT, 1'b1, 1'b0, 32'd0, "noar_no_rematch");
`endif

    // reset asserted while counting with state loaded
    wr(A_CNT, 32'd1234);
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h3);
    step(3);
    do_reset();
    check_reset_values("midrun");
    rd(1'b1, A_CNT, 1'b1, 1'b0, 32'h0, "midrun_count_div1");

    step(2);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
